// File: rtl/control_path_pkg.sv
// Shared control-path constants: condition selects, op-field bit positions
// and branch kinds used by the branch condition unit and its helpers.
package control_path_pkg;

  localparam logic [1:0] COND_ZERO = 2'd0;
  localparam logic [1:0] COND_SIGN = 2'd1;
  localparam logic [1:0] COND_OVER = 2'd2;
  localparam logic [1:0] COND_ERR  = 2'd3;

  localparam int OP_RELATIVE = 3;
  localparam int OP_INVERT   = 2;

  localparam logic KIND_FLAG = 1'b0;
  localparam logic KIND_LOOP = 1'b1;

endpackage

// File: rtl/loop_counter_bank.sv
// Bank of loop down-counters with a load port and a decrement port.
// A load to the same counter in the same cycle wins over the decrement.
module loop_counter_bank #(
  parameter int NUM_CTRS = 4,
  parameter int CTR_W    = 16,
  parameter int IDX_W    = $clog2(NUM_CTRS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic [IDX_W-1:0] load_idx,
  input  logic [CTR_W-1:0] load_val,
  input  logic             dec_en,
  input  logic [IDX_W-1:0] dec_idx,
  output logic [CTR_W-1:0] dec_val
);

  logic [CTR_W-1:0] ctr [NUM_CTRS];

  // Pre-update value minus one; the branch result always uses this even when
  // a same-cycle load overwrites the counter.
  assign dec_val = ctr[dec_idx] - CTR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CTRS; i++) ctr[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CTRS; i++) begin
        if (load_en && load_idx == IDX_W'(i)) begin
          ctr[i] <= load_val;
        end else if (dec_en && dec_idx == IDX_W'(i)) begin
          ctr[i] <= dec_val;
        end
      end
    end
  end

endmodule

// File: rtl/branch_condition_unit.sv
// Pipelined branch resolver: flag branches on per-register flags plus
// decrement-and-branch-if-nonzero loop branches, one output register stage.
module branch_condition_unit
  import control_path_pkg::*;
#(
  parameter int NUM_REGS      = 16,
  parameter int REG_IDX_W     = $clog2(NUM_REGS),
  parameter int NUM_LOOP_CTRS = 4,
  parameter int CTR_W         = 16,
  parameter int CTR_IDX_W     = $clog2(NUM_LOOP_CTRS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_kind,
  input  logic [3:0]           in_op,
  input  logic [REG_IDX_W-1:0] in_cond_reg,
  input  logic [REG_IDX_W-1:0] in_target_reg,
  input  logic [NUM_REGS-1:0]  zeroflag,
  input  logic [NUM_REGS-1:0]  signflag,
  input  logic [NUM_REGS-1:0]  overflow,
  input  logic [NUM_REGS-1:0]  errorbit,
  input  logic [NUM_REGS-1:0]  flag_busy,
  input  logic                 ctr_load_en,
  input  logic [CTR_IDX_W-1:0] ctr_load_idx,
  input  logic [CTR_W-1:0]     ctr_load_val,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_jump,
  output logic                 out_pc_increment,
  output logic                 out_relative,
  output logic [REG_IDX_W-1:0] out_target_reg
);

  localparam int PAD_W = 2 ** REG_IDX_W;

  // Handshake: a transfer happens on a side when valid && ready at the clock
  // edge. in_valid/out_valid never depend on the matching ready; in_ready is
  // a function of out state, out_ready and the interlock on the current
  // instruction (in_kind/in_cond_reg), which is deliberate.

  // Flag vectors are padded to the full index range so an out-of-range
  // register index reads a defined 0 instead of X.
  logic [PAD_W-1:0] zf_pad, sf_pad, of_pad, eb_pad, busy_pad;
  logic             flag_bit;
  logic             stall;
  logic             accept;
  logic             loop_dec;
  logic [CTR_W-1:0] ctr_dec_val;
  logic             loop_cond;
  logic             cond;

  always_comb begin
    zf_pad   = '0;
    sf_pad   = '0;
    of_pad   = '0;
    eb_pad   = '0;
    busy_pad = '0;
    zf_pad[NUM_REGS-1:0]   = zeroflag;
    sf_pad[NUM_REGS-1:0]   = signflag;
    of_pad[NUM_REGS-1:0]   = overflow;
    eb_pad[NUM_REGS-1:0]   = errorbit;
    busy_pad[NUM_REGS-1:0] = flag_busy;
  end

  always_comb begin
    flag_bit = 1'b0;
    case (in_op[1:0])
      COND_ZERO: flag_bit = zf_pad[in_cond_reg];
      COND_SIGN: flag_bit = sf_pad[in_cond_reg];
      COND_OVER: flag_bit = of_pad[in_cond_reg];
      COND_ERR:  flag_bit = eb_pad[in_cond_reg];
      default:   flag_bit = 1'b0;
    endcase
  end

  // Only flag branches wait on in-flight register writes; loop counters are
  // private to this unit.
  assign stall    = in_valid && (in_kind == KIND_FLAG) && busy_pad[in_cond_reg];
  assign in_ready = (!out_valid || out_ready) && !stall;
  assign accept   = in_valid && in_ready;
  assign loop_dec = accept && (in_kind == KIND_LOOP);

  loop_counter_bank #(
    .NUM_CTRS (NUM_LOOP_CTRS),
    .CTR_W    (CTR_W),
    .IDX_W    (CTR_IDX_W)
  ) u_ctr_bank (
    .clk      (clk),
    .rst      (rst),
    .load_en  (ctr_load_en),
    .load_idx (ctr_load_idx),
    .load_val (ctr_load_val),
    .dec_en   (loop_dec),
    .dec_idx  (in_cond_reg[CTR_IDX_W-1:0]),
    .dec_val  (ctr_dec_val)
  );

  assign loop_cond = (ctr_dec_val != '0) ^ in_op[OP_INVERT];
  assign cond      = (in_kind == KIND_LOOP) ? loop_cond : (flag_bit ^ in_op[OP_INVERT]);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid      <= 1'b0;
      out_jump       <= 1'b0;
      out_relative   <= 1'b0;
      out_target_reg <= '0;
    end else if (accept) begin
      out_valid      <= 1'b1;
      out_jump       <= cond;
      out_relative   <= in_op[OP_RELATIVE];
      out_target_reg <= in_target_reg;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_pc_increment = ~out_jump;

endmodule
